// File: rtl/frame_capture_avl_writer.sv
// Captures one frame of 24-bit pixels into a FIFO and writes it to LPDDR2
// as fixed-length Avalon-MM write bursts starting at a latched base address.
module frame_capture_avl_writer #(
  parameter int unsigned FRAME_WORDS = 2073600,
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned ADDR_W      = 27
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [ADDR_W-1:0] iBASE_ADDR,
  input  logic              iARM,
  input  logic              iPIX_VALID,
  input  logic              iPIX_SOF,
  input  logic [23:0]       iPIX_DATA,
  input  logic              avl_waitrequest_n,
  output logic [ADDR_W-1:0] avl_address,
  output logic [31:0]       avl_writedata,
  output logic              avl_write,
  output logic              avl_burstbegin,
  output logic [2:0]        avl_size,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oERR,
  output logic              oOVERFLOW
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam int unsigned CNT_W  = $clog2(FRAME_WORDS + 1);
  localparam int unsigned BEAT_W = 2;

  typedef enum logic [1:0] {IN_IDLE, IN_WAIT_SOF, IN_RUN, IN_END} in_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_REQ, WR_BURST} wr_state_t;

  in_state_t         in_state, in_state_d;
  wr_state_t         wr_state, wr_state_d;
  logic [CNT_W-1:0]  in_cnt, in_cnt_d;
  logic [CNT_W-1:0]  wr_cnt, wr_cnt_d;
  logic [BEAT_W-1:0] beat_cnt, beat_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              abort_q, abort_d;

  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic              write_d, bb_d;
  logic              busy_d, done_d, err_d, ovf_d;

  // Pixel FIFO
  logic [23:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [FCNT_W-1:0] fifo_cnt;
  logic              push, pop, flush;
  logic              full_after_pop;
  logic              last_beat;

  assign avl_size       = 3'(BURST_LEN);
  assign rd_ptr_nxt     = rd_ptr + PTR_W'(1);
  assign full_after_pop = (fifo_cnt - FCNT_W'(pop)) == FCNT_W'(FIFO_DEPTH);
  assign last_beat      = beat_cnt == BEAT_W'(BURST_LEN - 1);

  // State, counters, FIFO bookkeeping and registered outputs
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      in_state       <= IN_IDLE;
      wr_state       <= WR_IDLE;
      in_cnt         <= '0;
      wr_cnt         <= '0;
      beat_cnt       <= '0;
      base_q         <= '0;
      abort_q        <= 1'b0;
      avl_address    <= '0;
      avl_writedata  <= '0;
      avl_write      <= 1'b0;
      avl_burstbegin <= 1'b0;
      oBUSY          <= 1'b0;
      oDONE          <= 1'b0;
      oERR           <= 1'b0;
      oOVERFLOW      <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_cnt       <= '0;
    end else begin
      in_state       <= in_state_d;
      wr_state       <= wr_state_d;
      in_cnt         <= in_cnt_d;
      wr_cnt         <= wr_cnt_d;
      beat_cnt       <= beat_cnt_d;
      base_q         <= base_d;
      abort_q        <= abort_d;
      avl_address    <= addr_d;
      avl_writedata  <= wdata_d;
      avl_write      <= write_d;
      avl_burstbegin <= bb_d;
      oBUSY          <= busy_d;
      oDONE          <= done_d;
      oERR           <= err_d;
      oOVERFLOW      <= ovf_d;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr_nxt;
        case ({push, pop})
          2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
          2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
          default: fifo_cnt <= fifo_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (push) mem[wr_ptr] <= iPIX_DATA;
  end

  // Next-state logic for both FSMs and the status flags
  always_comb begin
    in_state_d = in_state;
    wr_state_d = wr_state;
    in_cnt_d   = in_cnt;
    wr_cnt_d   = wr_cnt;
    beat_cnt_d = beat_cnt;
    base_d     = base_q;
    abort_d    = abort_q;
    addr_d     = avl_address;
    wdata_d    = avl_writedata;
    write_d    = avl_write;
    bb_d       = avl_burstbegin;
    busy_d     = oBUSY;
    done_d     = oDONE;
    err_d      = oERR;
    ovf_d      = oOVERFLOW;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;

    // Write side first: pop feeds the input side's full check
    case (wr_state)
      WR_IDLE: begin
        if (oBUSY) begin
          if (abort_q) begin
            flush      = 1'b1;
            err_d      = 1'b1;
            busy_d     = 1'b0;
            in_state_d = IN_IDLE;
          end else if (fifo_cnt >= FCNT_W'(BURST_LEN)) begin
            write_d    = 1'b1;
            bb_d       = 1'b1;
            addr_d     = base_q + ADDR_W'(wr_cnt);
            wdata_d    = {8'h00, mem[rd_ptr]};
            beat_cnt_d = '0;
            wr_state_d = WR_REQ;
          end
        end
      end
      WR_REQ, WR_BURST: begin
        if (avl_waitrequest_n) begin
          pop  = 1'b1;
          bb_d = 1'b0;
          if (last_beat) begin
            write_d    = 1'b0;
            wr_cnt_d   = wr_cnt + CNT_W'(BURST_LEN);
            wr_state_d = WR_IDLE;
            if (!abort_q && wr_cnt_d == CNT_W'(FRAME_WORDS)) begin
              done_d     = 1'b1;
              busy_d     = 1'b0;
              in_state_d = IN_IDLE;
            end
          end else begin
            beat_cnt_d = beat_cnt + BEAT_W'(1);
            wdata_d    = {8'h00, mem[rd_ptr_nxt]};
            wr_state_d = WR_BURST;
          end
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase

    case (in_state)
      IN_IDLE: begin
        if (iARM) begin
          base_d     = iBASE_ADDR;
          done_d     = 1'b0;
          err_d      = 1'b0;
          ovf_d      = 1'b0;
          busy_d     = 1'b1;
          abort_d    = 1'b0;
          in_cnt_d   = '0;
          wr_cnt_d   = '0;
          in_state_d = IN_WAIT_SOF;
        end
      end
      IN_WAIT_SOF: begin
        if (iPIX_VALID && iPIX_SOF) begin
          push       = 1'b1;
          in_cnt_d   = CNT_W'(1);
          in_state_d = (FRAME_WORDS == 1) ? IN_END : IN_RUN;
        end
      end
      IN_RUN: begin
        if (iPIX_VALID) begin
          push     = 1'b1;
          in_cnt_d = in_cnt + CNT_W'(1);
          if (in_cnt_d == CNT_W'(FRAME_WORDS)) in_state_d = IN_END;
        end
      end
      default: ;
    endcase

    // A push into a full FIFO drops the pixel and aborts the capture
    if (push && full_after_pop) begin
      push       = 1'b0;
      in_cnt_d   = in_cnt;
      ovf_d      = 1'b1;
      abort_d    = 1'b1;
      in_state_d = IN_END;
    end
  end

endmodule

// File: tb/tb_frame_capture_avl_writer.sv
// Directed bench for frame_capture_avl_writer: small frame, beats collected
// by a monitor and compared against hand-computed addresses and pixels.
module tb_frame_capture_avl_writer;

  localparam int unsigned FW = 16;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic [26:0] iBASE_ADDR = '0;
  logic        iARM = 1'b0;
  logic        iPIX_VALID = 1'b0;
  logic        iPIX_SOF = 1'b0;
  logic [23:0] iPIX_DATA = '0;
  logic        avl_waitrequest_n = 1'b1;
  logic [26:0] avl_address;
  logic [31:0] avl_writedata;
  logic        avl_write;
  logic        avl_burstbegin;
  logic [2:0]  avl_size;
  logic        oBUSY, oDONE, oERR, oOVERFLOW;

  int total = 0;
  int bad   = 0;
  int stall_left = 0;
  bit toggle = 1'b0;

  logic [31:0] beat_addr[$];
  logic [31:0] beat_data[$];
  logic        beat_bb[$];
  int          stall_seen = 0;
  int          stall_viol = 0;
  bit          prev_stall = 1'b0;
  logic [26:0] prev_addr;
  logic [31:0] prev_data;

  frame_capture_avl_writer #(
    .FRAME_WORDS(FW), .BURST_LEN(4), .FIFO_DEPTH(8), .ADDR_W(27)
  ) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iBASE_ADDR(iBASE_ADDR), .iARM(iARM),
    .iPIX_VALID(iPIX_VALID), .iPIX_SOF(iPIX_SOF), .iPIX_DATA(iPIX_DATA),
    .avl_waitrequest_n(avl_waitrequest_n), .avl_address(avl_address),
    .avl_writedata(avl_writedata), .avl_write(avl_write),
    .avl_burstbegin(avl_burstbegin), .avl_size(avl_size),
    .oBUSY(oBUSY), .oDONE(oDONE), .oERR(oERR), .oOVERFLOW(oOVERFLOW)
  );

  always #5 iCLK = ~iCLK;

  // Beat collector and stall-stability watcher, sampled mid-cycle
  always @(negedge iCLK) begin
    if (!iRST_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!avl_write || avl_address != prev_addr || avl_writedata != prev_data))
        stall_viol <= stall_viol + 1;
      if (avl_write && avl_waitrequest_n) begin
        beat_addr.push_back(32'(avl_address));
        beat_data.push_back(avl_writedata);
        beat_bb.push_back(avl_burstbegin);
      end
      if (avl_write && !avl_waitrequest_n) stall_seen <= stall_seen + 1;
      prev_stall <= avl_write && !avl_waitrequest_n;
      prev_addr  <= avl_address;
      prev_data  <= avl_writedata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
    if (stall_left > 0) stall_left--;
    if (stall_left > 0) avl_waitrequest_n = 1'b0;
    else if (toggle)    avl_waitrequest_n = ~avl_waitrequest_n;
    else                avl_waitrequest_n = 1'b1;
  endtask

  task automatic arm(input logic [26:0] base);
    iBASE_ADDR = base;
    iARM = 1'b1;
    tick();
    iARM = 1'b0;
  endtask

  task automatic send_pix(input int n, input logic [23:0] first, input bit sof, input int gap);
    for (int i = 0; i < n; i++) begin
      iPIX_VALID = 1'b1;
      iPIX_DATA  = first + 24'(i);
      iPIX_SOF   = sof && (i == 0);
      tick();
      iPIX_VALID = 1'b0;
      iPIX_SOF   = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_end(input string tag);
    int c = 0;
    while (!(oDONE || oERR) && c < 400) begin
      tick();
      c++;
    end
    chk({tag, "_timeout"}, 32'(c < 400), 32'd1);
  endtask

  task automatic clear_beats();
    beat_addr.delete();
    beat_data.delete();
    beat_bb.delete();
  endtask

  task automatic check_frame(input string tag, input logic [26:0] base, input logic [23:0] first);
    chk({tag, "_nbeats"}, 32'(beat_data.size()), 32'(FW));
    for (int i = 0; i < beat_data.size() && i < int'(FW); i++) begin
      chk($sformatf("%s_data%0d", tag, i), beat_data[i], {8'h00, first + 24'(i)});
      chk($sformatf("%s_addr%0d", tag, i), beat_addr[i], 32'(base + 27'((i / 4) * 4)));
      chk($sformatf("%s_bb%0d", tag, i), 32'(beat_bb[i]), 32'((i % 4) == 0));
    end
  endtask

  initial begin
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_write", 32'(avl_write), 0);
    chk("rst_bb", 32'(avl_burstbegin), 0);
    chk("rst_addr", 32'(avl_address), 0);
    chk("rst_size", 32'(avl_size), 4);
    chk("rst_flags", {28'd0, oBUSY, oDONE, oERR, oOVERFLOW}, 0);
    iRST_n = 1'b1;
    tick();

    // Basic frame, continuous pixels, no stalls
    clear_beats();
    arm(27'h100);
    chk("t1_busy", 32'(oBUSY), 1);
    send_pix(16, 24'h000001, 1'b1, 0);
    wait_end("t1");
    chk("t1_done", 32'(oDONE), 1);
    chk("t1_err", 32'(oERR), 0);
    chk("t1_busy_end", 32'(oBUSY), 0);
    check_frame("t1", 27'h100, 24'h000001);

    // Leading non-SOF pixels discarded, trailing extras dropped
    clear_beats();
    arm(27'h200);
    send_pix(3, 24'hAA0001, 1'b0, 0);
    send_pix(20, 24'h000101, 1'b1, 0);
    wait_end("t2");
    repeat (10) tick();
    chk("t2_done", 32'(oDONE), 1);
    check_frame("t2", 27'h200, 24'h000101);

    // Alternating waitrequest
    clear_beats();
    stall_seen = 0;
    stall_viol = 0;
    toggle = 1'b1;
    arm(27'h080);
    send_pix(16, 24'h000301, 1'b1, 2);
    wait_end("t3");
    toggle = 1'b0;
    tick();
    chk("t3_done", 32'(oDONE), 1);
    chk("t3_stalls_seen", 32'(stall_seen != 0), 1);
    chk("t3_stall_hold", 32'(stall_viol), 0);
    check_frame("t3", 27'h080, 24'h000301);

    // Long stall forces overflow and abort
    clear_beats();
    stall_left = 41;
    arm(27'h180);
    send_pix(16, 24'h000201, 1'b1, 0);
    wait_end("t4");
    chk("t4_ovf", 32'(oOVERFLOW), 1);
    chk("t4_err", 32'(oERR), 1);
    chk("t4_done", 32'(oDONE), 0);
    chk("t4_busy", 32'(oBUSY), 0);
    chk("t4_nbeats", 32'(beat_data.size()), 4);
    for (int i = 0; i < beat_data.size() && i < 4; i++) begin
      chk($sformatf("t4_data%0d", i), beat_data[i], 32'h00000201 + 32'(i));
      chk($sformatf("t4_addr%0d", i), beat_addr[i], 32'h180);
    end
    repeat (20) tick();
    chk("t4_no_more", 32'(beat_data.size()), 4);

    // Re-arm after error; arm while busy is ignored
    clear_beats();
    arm(27'h300);
    chk("t5_flags_clr", {29'd0, oDONE, oERR, oOVERFLOW}, 0);
    arm(27'h500);
    send_pix(16, 24'h000401, 1'b1, 0);
    wait_end("t5a");
    chk("t5a_done", 32'(oDONE), 1);
    check_frame("t5a", 27'h300, 24'h000401);
    clear_beats();
    arm(27'h400);
    chk("t5b_done_clr", 32'(oDONE), 0);
    chk("t5b_busy", 32'(oBUSY), 1);
    send_pix(16, 24'h000501, 1'b1, 0);
    wait_end("t5b");
    chk("t5b_done", 32'(oDONE), 1);
    check_frame("t5b", 27'h400, 24'h000501);

    // Asynchronous reset during a stalled burst
    stall_left = 30;
    arm(27'h600);
    send_pix(8, 24'h000601, 1'b1, 0);
    chk("t6_write_before", 32'(avl_write), 1);
    #2;
    iRST_n = 1'b0;
    #1;
    chk("t6_write_async", 32'(avl_write), 0);
    chk("t6_flags", {28'd0, oBUSY, oDONE, oERR, oOVERFLOW}, 0);
    stall_left = 0;
    repeat (2) tick();
    iRST_n = 1'b1;
    tick();
    clear_beats();
    arm(27'h700);
    send_pix(16, 24'h000701, 1'b1, 0);
    wait_end("t6");
    chk("t6_done", 32'(oDONE), 1);
    chk("t6_err", 32'(oERR), 0);
    check_frame("t6", 27'h700, 24'h000701);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
